// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic [ADDR_W_DEF-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_W_DEF-1:0] rd;
        logic [DATA_W_DEF-1:0] data;
    } lu_entry_t;

endpackage

// File: rtl/wb_lu_fifo.sv
// Long-latency-unit result buffer; every stored entry can be invalidated by a
// destination-register match so a younger pipeline write kills stale results.
module wb_lu_fifo #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_rd_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    input  logic              inv_i,
    input  logic [ADDR_W-1:0] inv_rd_i,
    output logic              head_valid_o,
    output logic [ADDR_W-1:0] head_rd_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic              empty_o,
    output logic              full_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]  valid_q;
    logic [ADDR_W-1:0] rd_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Invalidate before the push so an entry written this cycle survives.
            for (int i = 0; i < DEPTH; i++) begin
                if (inv_i && rd_q[i] == inv_rd_i) valid_q[i] <= 1'b0;
            end
            if (push_i) begin
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= wr_ptr_q + 1'b1;
            end
            if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            rd_q[wr_ptr_q]   <= push_rd_i;
            data_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_valid_o = valid_q[rd_ptr_q];
    assign head_rd_o    = rd_q[rd_ptr_q];
    assign head_data_o  = data_q[rd_ptr_q];
    assign empty_o      = (count_q == '0);
    assign full_o       = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between MEM/WB and the long-latency unit,
// with pipeline priority and a one-cycle forced stall when the LU head starves.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_reg_write,
    input  logic              wb_mem_to_reg,
    input  logic [DATA_W-1:0] wb_mem_data,
    input  logic [DATA_W-1:0] wb_alu_result,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [ADDR_W-1:0] lu_rd,
    input  logic [DATA_W-1:0] lu_data,
    output logic              wb_stall,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    logic              pipe_req, push, pop_wr, discard, blocked, head_live;
    logic              fifo_empty, fifo_full, head_valid;
    logic [ADDR_W-1:0] head_rd;
    logic [DATA_W-1:0] head_data, pipe_data;

    logic [STV_W-1:0]  starve_q, starve_d;
    logic              stall_q, stall_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

    wb_lu_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push),
        .push_rd_i    (lu_rd),
        .push_data_i  (lu_data),
        .pop_i        (pop_wr | discard),
        .inv_i        (pipe_req),
        .inv_rd_i     (wb_rd),
        .head_valid_o (head_valid),
        .head_rd_o    (head_rd),
        .head_data_o  (head_data),
        .empty_o      (fifo_empty),
        .full_o       (fifo_full)
    );

    always_comb begin
        pipe_req  = wb_reg_write && (wb_rd != ADDR_W'(REG_ZERO)) && !stall_q;
        pipe_data = wb_mem_to_reg ? wb_mem_data : wb_alu_result;
        head_live = !fifo_empty && head_valid;
        blocked   = head_live && pipe_req;
        pop_wr    = head_live && !pipe_req;
        discard   = !fifo_empty && !head_valid && !pipe_req;
        push      = lu_valid && !fifo_full && (lu_rd != ADDR_W'(REG_ZERO));
    end

    always_comb begin
        rf_we_d    = pipe_req | pop_wr;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (pipe_req) begin
            rf_waddr_d = wb_rd;
            rf_wdata_d = pipe_data;
        end else if (pop_wr) begin
            rf_waddr_d = head_rd;
            rf_wdata_d = head_data;
        end

        // Stall fires on the blocked cycle that reaches the limit; the stall
        // cycle itself drops pipe_req, so the head always leaves next cycle.
        stall_d  = blocked && (starve_q == STV_W'(STARVE_LIMIT - 1));
        starve_d = starve_q;
        if (fifo_empty || pop_wr || discard) starve_d = '0;
        else if (blocked)                    starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q   <= '0;
            stall_q    <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            starve_q   <= starve_d;
            stall_q    <= stall_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign lu_ready = !fifo_full;
    assign wb_stall = stall_q;
    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized bench for wb_port_arbiter against a queue-based reference model.
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_reg_write, wb_mem_to_reg;
    logic [31:0] wb_mem_data, wb_alu_result;
    logic [4:0]  wb_rd;
    logic        lu_valid, lu_ready;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        wb_stall, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .DATA_W       (32),
        .ADDR_W       (5),
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb_reg_write  (wb_reg_write),
        .wb_mem_to_reg (wb_mem_to_reg),
        .wb_mem_data   (wb_mem_data),
        .wb_alu_result (wb_alu_result),
        .wb_rd         (wb_rd),
        .lu_valid      (lu_valid),
        .lu_ready      (lu_ready),
        .lu_rd         (lu_rd),
        .lu_data       (lu_data),
        .wb_stall      (wb_stall),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: queue of buffered LU results in arrival order.
    lu_entry_t   mq[$];
    int          m_starve;
    bit          m_stall;
    bit          m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_starve = 0;
        m_stall  = 0;
        m_we     = 0;
        m_waddr  = '0;
        m_wdata  = '0;
    endtask

    task automatic model_step();
        bit preq, ready, live, nstall;
        nstall = 0;
        preq   = wb_reg_write && (wb_rd != 0) && !m_stall;
        ready  = mq.size() < DEPTH;
        live   = (mq.size() > 0) && mq[0].valid;
        m_we   = 0;
        if (preq) begin
            m_we    = 1;
            m_waddr = wb_rd;
            m_wdata = wb_mem_to_reg ? wb_mem_data : wb_alu_result;
            if (live) begin
                if (m_starve == LIMIT - 1) nstall = 1;
                m_starve++;
            end
            foreach (mq[i]) if (mq[i].rd == wb_rd) mq[i].valid = 1'b0;
        end else if (mq.size() > 0) begin
            if (mq[0].valid) begin
                m_we    = 1;
                m_waddr = mq[0].rd;
                m_wdata = mq[0].data;
            end
            void'(mq.pop_front());
            m_starve = 0;
        end
        if (lu_valid && ready && lu_rd != 0)
            mq.push_back('{valid: 1'b1, rd: lu_rd, data: lu_data});
        m_stall = nstall;
    endtask

    // One clock: drive at negedge (pipe inputs held while stalled), model, check after posedge.
    task automatic step(input bit wr, input bit m2r, input logic [31:0] md, input logic [31:0] alu,
                        input logic [4:0] rd, input bit lv, input logic [4:0] lrd,
                        input logic [31:0] ld);
        @(negedge clk);
        if (!m_stall) begin
            wb_reg_write  = wr;
            wb_mem_to_reg = m2r;
            wb_mem_data   = md;
            wb_alu_result = alu;
            wb_rd         = rd;
        end
        lu_valid = lv;
        lu_rd    = lrd;
        lu_data  = ld;
        model_step();
        @(posedge clk);
        #1;
        check_eq("rf_we", rf_we, m_we);
        check_eq("rf_waddr", rf_waddr, m_waddr);
        check_eq("rf_wdata", rf_wdata, m_wdata);
        check_eq("wb_stall", wb_stall, m_stall);
        check_eq("lu_ready", lu_ready, mq.size() < DEPTH);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [4:0] rnd_rd();
        case ($urandom_range(0, 4))
            0:       return 5'd0;
            1:       return 5'($urandom_range(1, 3));
            2:       return 5'd7;
            default: return 5'($urandom);
        endcase
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rst_rf_we", rf_we, 0);
        check_eq("rst_rf_waddr", rf_waddr, 0);
        check_eq("rst_rf_wdata", rf_wdata, 0);
        check_eq("rst_wb_stall", wb_stall, 0);
        wb_reg_write = 0; wb_mem_to_reg = 0; wb_mem_data = 0; wb_alu_result = 0; wb_rd = 0;
        lu_valid = 0; lu_rd = 0; lu_data = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_lu_ready", lu_ready, 1);
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        wb_reg_write = 0; wb_mem_to_reg = 0; wb_mem_data = 0; wb_alu_result = 0; wb_rd = 0;
        lu_valid = 0; lu_rd = 0; lu_data = 0;
        model_reset();
        apply_reset();

        // MemtoReg select
        step(1, 0, 32'h22, 32'h11, 5'd5, 0, 0, 0);
        check_eq("t1_alu_data", rf_wdata, 32'h11);
        step(1, 1, 32'h22, 32'h11, 5'd5, 0, 0, 0);
        check_eq("t1_mem_data", rf_wdata, 32'h22);

        // LU result through an idle slot
        step(0, 0, 0, 0, 0, 1, 5'd9, 32'hABCD);
        idle();
        check_eq("t2_lu_waddr", rf_waddr, 9);
        check_eq("t2_lu_wdata", rf_wdata, 32'hABCD);

        // WAW squash: pipe write to rd 7 kills buffered LU rd 7
        step(0, 0, 0, 0, 0, 1, 5'd7, 32'h77);
        step(1, 0, 0, 32'h70, 5'd7, 0, 0, 0);
        check_eq("t4_pipe_data", rf_wdata, 32'h70);
        idle();
        check_eq("t4_no_lu_write", rf_we, 0);

        // Writes to $0 are dropped on both sides
        step(1, 0, 0, 32'h55, 5'd0, 1, 5'd0, 32'h66);
        check_eq("t5_pipe_r0", rf_we, 0);
        idle();
        check_eq("t5_lu_r0", rf_we, 0);

        // Fill FIFO under continuous pipe writes, wait for the forced stall
        step(1, 0, 0, 32'h100, 5'd5, 1, 5'd9, 32'h900);
        step(1, 0, 0, 32'h101, 5'd5, 1, 5'd10, 32'hA00);
        check_eq("t3_full", lu_ready, 0);
        k = 0;
        while (!m_stall && k < 20) begin
            step(1, 0, 0, 32'h200 + k, 5'd5, 1, 5'd11, 32'hB00);
            k++;
        end
        check_eq("t3_stall_seen", wb_stall, 1);
        step(1, 0, 0, 32'h300, 5'd6, 1, 5'd11, 32'hB00);
        check_eq("t3_head_waddr", rf_waddr, 9);
        check_eq("t3_head_wdata", rf_wdata, 32'h900);
        k = 0;
        while (!m_stall && k < 20) begin
            step(1, 0, 0, 32'h400 + k, 5'd5, 1, 5'd12, 32'hC00);
            k++;
        end
        check_eq("t6_stall_before_reset", wb_stall, 1);
        apply_reset();
        idle();
        check_eq("t6_empty_after_reset", rf_we, 0);

        // Randomized phases: pipe-heavy, LU-heavy, mixed
        for (int p = 0; p < 3; p++) begin
            int pw, lw;
            pw = (p == 0) ? 90 : (p == 1) ? 30 : 60;
            lw = (p == 0) ? 50 : (p == 1) ? 90 : 60;
            for (int c = 0; c < 600; c++) begin
                step($urandom_range(0, 99) < pw, 1'($urandom), $urandom, $urandom, rnd_rd(),
                     $urandom_range(0, 99) < lw, rnd_rd(), $urandom);
            end
            for (int c = 0; c < 6; c++) idle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
